// File: rtl/fccc_lock_sequencer_pkg.sv
// +----------------------------------------------------------------------+
// | fccc_seq_pkg : shared types and helpers for the CCC lock sequencer   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package fccc_seq_pkg;

   typedef enum logic [2:0] {
      PLL_RESET = 3'd0,
      WAIT_LOCK = 3'd1,
      STABLE    = 3'd2,
      RELEASE   = 3'd3,
      RUN       = 3'd4,
      LOST      = 3'd5,
      FAULT     = 3'd6
   } state_e;

   function automatic int unsigned clog2(input int unsigned value);
      int unsigned result;
      int unsigned rem;
      result = 0;
      rem    = (value > 0) ? value - 1 : 0;
      while (rem != 0) begin
         result = result + 1;
         rem    = rem >> 1;
      end
      return result;
   endfunction

endpackage

`default_nettype wire

// File: rtl/fccc_lock_sequencer_lock_sync.sv
// +----------------------------------------------------------------------+
// | lock_sync : two-flop synchronizer, async active-low reset to 0       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module lock_sync (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic async_i,
   output logic sync_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= async_i;
         sync_q <= meta_q;
      end
   end

   assign sync_o = sync_q;

endmodule

`default_nettype wire

// File: rtl/fccc_lock_sequencer.sv
// +----------------------------------------------------------------------+
// | fccc_lock_sequencer : PLL reset / lock qualification / reset release |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module fccc_lock_sequencer
   import fccc_seq_pkg::*;
#(
   parameter int unsigned PLL_RST_CYCLES = 16,
   parameter int unsigned LOCK_TIMEOUT   = 65536,
   parameter int unsigned LOCK_STABLE    = 1024,
   parameter int unsigned RELEASE_DELAY  = 64,
   parameter int unsigned GLITCH_CYCLES  = 4,
   parameter int unsigned MAX_RETRIES    = 3,
   parameter bit          AUTO_RESTART   = 1'b1,
   parameter int unsigned CNT_W          = 17,
   parameter int unsigned LOSS_W         = 8
) (
   input  logic              clk0_i,
   input  logic              arst_n_i,
   input  logic              lock_i,
   input  logic              sw_restart_i,
   output logic              pll_arst_n_o,
   output logic              pll_powerdown_n_o,
   output logic              sys_reset_n_o,
   output logic              ready_o,
   output logic              fault_o,
   output logic [LOSS_W-1:0] loss_count_o,
   output logic [2:0]        state_o
);

   localparam int unsigned RETRY_W = clog2(MAX_RETRIES + 1);

   localparam logic [CNT_W-1:0]   PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
   localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);
   localparam logic [CNT_W-1:0]   RELEASE_LAST = CNT_W'(RELEASE_DELAY - 1);
   localparam logic [CNT_W-1:0]   GLITCH_LAST  = CNT_W'(GLITCH_CYCLES - 1);
   localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRIES);

   if (PLL_RST_CYCLES == 0 || LOCK_TIMEOUT == 0 || LOCK_STABLE == 0 ||
       RELEASE_DELAY == 0 || GLITCH_CYCLES == 0 || MAX_RETRIES == 0 ||
       CNT_W == 0 || LOSS_W == 0) begin : g_zero_param
      $fatal(1, "fccc_lock_sequencer: zero-valued parameter");
   end

   if ((longint'(LOCK_TIMEOUT) > (longint'(1) << CNT_W)) ||
       (longint'(LOCK_STABLE) > (longint'(1) << CNT_W))) begin : g_cnt_too_narrow
      $fatal(1, "fccc_lock_sequencer: CNT_W too narrow for cycle parameters");
   end

   logic lock_s;

   lock_sync u_lock_sync (
      .clk_i   (clk0_i),
      .rst_ni  (arst_n_i),
      .async_i (lock_i),
      .sync_o  (lock_s)
   );

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [RETRY_W-1:0]  retries_q, retries_d;
   logic [LOSS_W-1:0]   loss_q, loss_d;
   logic                pll_arst_n_q, pll_powerdown_n_q, sys_reset_n_q, ready_q, fault_q;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q + 1'b1;
      retries_d = retries_q;
      loss_d    = loss_q;

      if (sw_restart_i) begin
         state_d   = PLL_RESET;
         retries_d = '0;
      end else begin
         unique case (state_q)
            PLL_RESET: if (cnt_q == PLL_RST_LAST) state_d = WAIT_LOCK;
            WAIT_LOCK: begin
               if (lock_s) begin
                  state_d = STABLE;
               end else if (cnt_q == TIMEOUT_LAST) begin
                  retries_d = retries_q + 1'b1;
                  state_d   = (retries_d == RETRY_LIMIT) ? FAULT : PLL_RESET;
               end
            end
            STABLE: begin
               if (!lock_s)                     state_d = WAIT_LOCK;
               else if (cnt_q == STABLE_LAST)   state_d = RELEASE;
            end
            RELEASE: begin
               if (!lock_s) begin
                  state_d = WAIT_LOCK;
               end else if (cnt_q == RELEASE_LAST) begin
                  state_d   = RUN;
                  retries_d = '0;
               end
            end
            RUN: begin
               // Counter doubles as the consecutive-dropout filter here.
               if (lock_s) begin
                  cnt_d = '0;
               end else if (cnt_q == GLITCH_LAST) begin
                  state_d = LOST;
                  loss_d  = (&loss_q) ? loss_q : loss_q + 1'b1;
               end
            end
            LOST:    state_d = AUTO_RESTART ? PLL_RESET : WAIT_LOCK;
            FAULT:   cnt_d   = cnt_q;
            default: state_d = PLL_RESET;
         endcase
      end

      if (sw_restart_i || (state_d != state_q)) cnt_d = '0;
   end

   always_ff @(posedge clk0_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         state_q           <= PLL_RESET;
         cnt_q             <= '0;
         retries_q         <= '0;
         loss_q            <= '0;
         pll_arst_n_q      <= 1'b0;
         pll_powerdown_n_q <= 1'b1;
         sys_reset_n_q     <= 1'b0;
         ready_q           <= 1'b0;
         fault_q           <= 1'b0;
      end else begin
         state_q           <= state_d;
         cnt_q             <= cnt_d;
         retries_q         <= retries_d;
         loss_q            <= loss_d;
         pll_arst_n_q      <= (state_d != PLL_RESET);
         pll_powerdown_n_q <= (state_d != FAULT);
         sys_reset_n_q     <= (state_d == RUN);
         ready_q           <= (state_d == RUN);
         fault_q           <= (state_d == FAULT);
      end
   end

   assign pll_arst_n_o      = pll_arst_n_q;
   assign pll_powerdown_n_o = pll_powerdown_n_q;
   assign sys_reset_n_o     = sys_reset_n_q;
   assign ready_o           = ready_q;
   assign fault_o           = fault_q;
   assign loss_count_o      = loss_q;
   assign state_o           = state_q;

endmodule

`default_nettype wire

// File: tb/tb_fccc_lock_sequencer.sv
// +----------------------------------------------------------------------+
// | tb_fccc_lock_sequencer : directed bench for the CCC lock sequencer   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_fccc_lock_sequencer;

   localparam logic [2:0] S_PLL_RESET = 3'd0;
   localparam logic [2:0] S_WAIT_LOCK = 3'd1;
   localparam logic [2:0] S_STABLE    = 3'd2;
   localparam logic [2:0] S_RELEASE   = 3'd3;
   localparam logic [2:0] S_RUN       = 3'd4;
   localparam logic [2:0] S_LOST      = 3'd5;
   localparam logic [2:0] S_FAULT     = 3'd6;

   logic       clk;
   logic       arst_n;
   logic       lock;
   logic       sw_restart;
   logic       pll_arst_n;
   logic       pll_powerdown_n;
   logic       sys_reset_n;
   logic       ready;
   logic       fault;
   logic [7:0] loss_count;
   logic [2:0] state;

   int vectors     = 0;
   int miscompares = 0;
   int exp_loss;

   fccc_lock_sequencer #(
      .PLL_RST_CYCLES (4),
      .LOCK_TIMEOUT   (100),
      .LOCK_STABLE    (10),
      .RELEASE_DELAY  (5),
      .GLITCH_CYCLES  (3),
      .MAX_RETRIES    (2),
      .AUTO_RESTART   (1'b1),
      .CNT_W          (17),
      .LOSS_W         (8)
   ) dut (
      .clk0_i            (clk),
      .arst_n_i          (arst_n),
      .lock_i            (lock),
      .sw_restart_i      (sw_restart),
      .pll_arst_n_o      (pll_arst_n),
      .pll_powerdown_n_o (pll_powerdown_n),
      .sys_reset_n_o     (sys_reset_n),
      .ready_o           (ready),
      .fault_o           (fault),
      .loss_count_o      (loss_count),
      .state_o           (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic wait_state(input logic [2:0] target, input int budget, input string tag);
      int n;
      n = 0;
      while (state !== target && n < budget) begin
         step(1);
         n++;
      end
      vectors++;
      assert (state === target) else begin
         miscompares++;
         $error("FAIL %s: state=%0d expected=%0d after %0d cycles", tag, state, target, n);
      end
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_pll_arst_n"}, 32'(pll_arst_n), 32'd0);
      check({tag, "_powerdown_n"}, 32'(pll_powerdown_n), 32'd1);
      check({tag, "_sys_reset_n"}, 32'(sys_reset_n), 32'd0);
      check({tag, "_ready"}, 32'(ready), 32'd0);
      check({tag, "_fault"}, 32'(fault), 32'd0);
      check({tag, "_loss"}, 32'(loss_count), 32'd0);
      check({tag, "_state"}, 32'(state), 32'(S_PLL_RESET));
   endtask

   initial begin
      arst_n     = 1'b0;
      lock       = 1'b0;
      sw_restart = 1'b0;
      #23;
      check_reset_values("reset");

      // Nominal bring-up: edge 0 is the first edge after release.
      @(posedge clk);
      #1;
      arst_n = 1'b1;
      step(3);
      check("nom_pll_arst_edge2", 32'(pll_arst_n), 32'd0);
      step(1);
      check("nom_pll_arst_edge3", 32'(pll_arst_n), 32'd1);
      check("nom_wait_edge3", 32'(state), 32'(S_WAIT_LOCK));
      step(16);
      lock = 1'b1;
      step(2);
      check("nom_sync_latency", 32'(state), 32'(S_WAIT_LOCK));
      step(1);
      check("nom_stable_edge22", 32'(state), 32'(S_STABLE));
      step(14);
      check("nom_release_edge36", 32'(state), 32'(S_RELEASE));
      check("nom_sysrst_edge36", 32'(sys_reset_n), 32'd0);
      step(1);
      check("nom_sysrst_edge37", 32'(sys_reset_n), 32'd1);
      check("nom_ready_edge37", 32'(ready), 32'd1);
      check("nom_state_edge37", 32'(state), 32'(S_RUN));
      check("nom_loss", 32'(loss_count), 32'd0);

      // Two-cycle dropout is filtered.
      lock = 1'b0;
      step(2);
      lock = 1'b1;
      step(4);
      check("glitch2_ready", 32'(ready), 32'd1);
      check("glitch2_state", 32'(state), 32'(S_RUN));

      // Sustained dropout: lost after three synced-low cycles.
      lock = 1'b0;
      step(4);
      check("loss_still_run", 32'(ready), 32'd1);
      step(1);
      check("loss_state", 32'(state), 32'(S_LOST));
      check("loss_sysrst", 32'(sys_reset_n), 32'd0);
      check("loss_ready", 32'(ready), 32'd0);
      check("loss_count1", 32'(loss_count), 32'd1);
      step(1);
      check("loss_pll_rst_start", 32'(pll_arst_n), 32'd0);
      step(3);
      check("loss_pll_rst_last", 32'(pll_arst_n), 32'd0);
      step(1);
      check("loss_pll_rst_end", 32'(pll_arst_n), 32'd1);
      check("loss_wait", 32'(state), 32'(S_WAIT_LOCK));

      // Lock bounce during STABLE.
      lock = 1'b1;
      step(4);
      check("bounce_stable", 32'(state), 32'(S_STABLE));
      step(1);
      lock = 1'b0;
      step(1);
      lock = 1'b1;
      step(1);
      check("bounce_still_stable", 32'(state), 32'(S_STABLE));
      step(1);
      check("bounce_back_wait", 32'(state), 32'(S_WAIT_LOCK));
      step(15);
      check("bounce_sysrst_k22", 32'(sys_reset_n), 32'd0);
      step(1);
      check("bounce_sysrst_k23", 32'(sys_reset_n), 32'd1);

      // Software restart from RUN, then timeouts into FAULT.
      sw_restart = 1'b1;
      lock       = 1'b0;
      step(1);
      sw_restart = 1'b0;
      check("swr_state", 32'(state), 32'(S_PLL_RESET));
      check("swr_sysrst", 32'(sys_reset_n), 32'd0);
      step(103);
      check("to_wait_s103", 32'(state), 32'(S_WAIT_LOCK));
      step(1);
      check("to_retry_pll_rst", 32'(pll_arst_n), 32'd0);
      step(4);
      check("to_wait2", 32'(state), 32'(S_WAIT_LOCK));
      step(99);
      check("to_no_fault_yet", 32'(fault), 32'd0);
      step(1);
      check("to_fault", 32'(fault), 32'd1);
      check("to_powerdown", 32'(pll_powerdown_n), 32'd0);
      check("to_fault_state", 32'(state), 32'(S_FAULT));
      step(5);
      check("to_fault_holds", 32'(state), 32'(S_FAULT));
      sw_restart = 1'b1;
      step(1);
      sw_restart = 1'b0;
      check("fault_swr_state", 32'(state), 32'(S_PLL_RESET));
      check("fault_swr_fault", 32'(fault), 32'd0);
      check("fault_swr_powerdown", 32'(pll_powerdown_n), 32'd1);
      check("fault_swr_loss_kept", 32'(loss_count), 32'd1);

      // Repeated forced losses: count saturates at all-ones.
      exp_loss = 1;
      for (int i = 0; i < 300; i++) begin
         lock = 1'b1;
         wait_state(S_RUN, 100, "sat_reach_run");
         lock = 1'b0;
         wait_state(S_LOST, 20, "sat_reach_lost");
         exp_loss = (exp_loss < 255) ? exp_loss + 1 : 255;
         if (i == 9 || i == 253 || i == 299)
            check("sat_loss_count", 32'(loss_count), 32'(exp_loss));
      end

      // Asynchronous reset mid-RELEASE.
      lock = 1'b1;
      wait_state(S_RELEASE, 100, "arst_reach_release");
      step(2);
      #3;
      arst_n = 1'b0;
      #1;
      check_reset_values("arst");
      #10;
      arst_n = 1'b1;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/fccc_lock_sequencer.md
Name: fccc_lock_sequencer

Overview:
- Sequences the fabric CCC (PLL) at startup and after lock loss.
  - Holds the PLL in reset, waits for and qualifies LOCK, then releases the downstream system reset.
- On lock loss: re-asserts the system reset, counts the event and optionally restarts the PLL.
- Sits beside the CCC wrapper on the free-running reference clock, and gates the counter datapath running on GL0.

Parameters:
- PLL_RST_CYCLES, 16: cycles PLL_ARST_N is held low per PLL reset.
- LOCK_TIMEOUT, 65536: cycles allowed in WAIT_LOCK before a retry.
- LOCK_STABLE, 1024: consecutive synced-LOCK-high cycles required to qualify lock.
- RELEASE_DELAY, 64: cycles between qualified lock and SYS_RESET_N release.
- GLITCH_CYCLES, 4: consecutive synced-LOCK-low cycles in RUN that count as lock loss.
- MAX_RETRIES, 3: lock timeouts tolerated before FAULT.
- AUTO_RESTART, 1: 1 means lock loss pulses the PLL reset; 0 means wait for relock only.
- CNT_W, 17: shared cycle counter width; must hold max(all cycle parameters).
- LOSS_W, 8: LOSS_COUNT width.

Ports:
- CLK0  in  1  free-running reference clock; same net that feeds the CCC CLK0.
- ARST_N  in  1  asynchronous, active-low reset.
- LOCK  in  1  CCC LOCK, asynchronous to CLK0.
- SW_RESTART  in  1  single-cycle request to restart the sequence.
- PLL_ARST_N  out  1  to CCC PLL_ARST_N.
- PLL_POWERDOWN_N  out  1  to CCC PLL_POWERDOWN_N.
- SYS_RESET_N  out  1  downstream reset, active low.
- READY  out  1  high only in RUN.
- FAULT  out  1  high only in FAULT.
- LOSS_COUNT  out  LOSS_W  saturating count of lock-loss events.
- STATE  out  3  current state encoding, for debug.

Behaviour:
- Reset (ARST_N=0, asynchronous): state=PLL_RESET, counters 0, retries 0, LOSS_COUNT 0.
  - Outputs: PLL_ARST_N=0, PLL_POWERDOWN_N=1, SYS_RESET_N=0, READY=0, FAULT=0.
- LOCK passes a 2-FF synchronizer (lock_s); 2-cycle latency.
- All outputs are registered and decoded from the next state, so each output changes on the same edge as the state.
- The cycle counter clears on every state entry.
- PLL_RESET: PLL_ARST_N=0. After PLL_RST_CYCLES cycles go to WAIT_LOCK with PLL_ARST_N=1.
- WAIT_LOCK:
  - lock_s=1 goes to STABLE.
  - Counter reaching LOCK_TIMEOUT-1 increments retries.
  - Then: if retries == MAX_RETRIES go to FAULT, else go to PLL_RESET.
- STABLE:
  - lock_s=0 goes to WAIT_LOCK (no retry increment; timeout restarts).
  - LOCK_STABLE consecutive high cycles go to RELEASE.
- RELEASE:
  - lock_s=0 goes to WAIT_LOCK.
  - After RELEASE_DELAY cycles go to RUN.
- RUN:
  - Outputs: SYS_RESET_N=1, READY=1.
  - Retries clear on entry.
  - Glitch counter counts consecutive lock_s=0 cycles and clears on lock_s=1.
  - Reaching GLITCH_CYCLES goes to LOST; shorter dropouts are ignored.
- LOST (1 cycle):
  - SYS_RESET_N=0.
  - LOSS_COUNT += 1, saturating at all-ones.
  - Then: AUTO_RESTART=1 goes to PLL_RESET, else WAIT_LOCK.
- FAULT: PLL_POWERDOWN_N=0, FAULT=1, SYS_RESET_N=0. Stays until SW_RESTART or ARST_N.
- SW_RESTART:
  - Highest priority, from any state including FAULT.
  - Goes to PLL_RESET next cycle; retries clear, SYS_RESET_N drops the same edge.
  - LOSS_COUNT is kept; only ARST_N clears it.
- Required timing: LOCK first sampled high at edge k (stable thereafter, from WAIT_LOCK) means SYS_RESET_N rises at edge k+2+LOCK_STABLE+RELEASE_DELAY.
- Counter compares use == on CNT_W-bit values. Parameter values of 0 are illegal; flag them with an elaboration assertion.
- ARST_N asserted mid-sequence returns everything to reset values immediately; no partial state is kept.

Decomposition:
- Package fccc_seq_pkg:
  - state enum: PLL_RESET=0, WAIT_LOCK=1, STABLE=2, RELEASE=3, RUN=4, LOST=5, FAULT=6.
  - a clog2 helper function.
- Sub-module lock_sync: 2-FF synchronizer with async active-low reset to 0.
- Everything else lives in one FSM plus counters.

Test Plan:
- Bench parameters: PLL_RST_CYCLES=4, LOCK_TIMEOUT=100, LOCK_STABLE=10, RELEASE_DELAY=5, GLITCH_CYCLES=3, MAX_RETRIES=2, AUTO_RESTART=1.
- Nominal bring-up: release ARST_N, raise LOCK at edge 20 → PLL_ARST_N low for edges 0–3; SYS_RESET_N and READY rise at edge 37; LOSS_COUNT=0.
- Lock bounce during STABLE: LOCK low 1 cycle, 5 cycles after rising → return to WAIT_LOCK, no retry; SYS_RESET_N rises 17 cycles after LOCK re-rises.
- Glitch filter in RUN: LOCK low 2 cycles → READY stays 1. LOCK low 3+ cycles → SYS_RESET_N=0, LOSS_COUNT=1, PLL_ARST_N pulses low for 4 cycles.
- Timeout/fault: LOCK held 0 → two PLL_RESET pulses 104 cycles apart, then FAULT=1 and PLL_POWERDOWN_N=0. SW_RESTART pulse → PLL_RESET, FAULT=0.
- Saturation and reset: 300 forced losses with LOSS_W=8 → LOSS_COUNT=255. ARST_N asserted mid-RELEASE → all outputs at reset values within the same cycle, asynchronously.
